// File: rtl/ofm_checker_pkg.sv
// Shared definitions for the OFM self-check engine: state encoding, geometry
// helper, channel-index width and a saturating counter step.
package ofm_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int CHAN_WIDTH = 8;

  function automatic int ofm_words(input int ofm_size, input int no_filter);
    return ofm_size * ofm_size * no_filter;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ofm_cmp_pipe.sv
// Tracks issued read addresses across the memory read latency and compares the
// two returning words with a signed tolerance; emits one registered verdict per cycle.
module ofm_cmp_pipe
  import ofm_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 17,
  parameter int RD_LATENCY = 1,
  parameter int TOL        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [CHAN_WIDTH-1:0] issue_chan,
  input  logic [DATA_WIDTH-1:0] rtl_data,
  input  logic [DATA_WIDTH-1:0] gld_data,
  output logic                  pending,
  output logic                  res_valid,
  output logic                  res_mismatch,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [CHAN_WIDTH-1:0] res_chan,
  output logic [DATA_WIDTH-1:0] res_rtl,
  output logic [DATA_WIDTH-1:0] res_gld
);

  localparam logic [DATA_WIDTH:0] TOL_V = (DATA_WIDTH+1)'(TOL);

  logic [RD_LATENCY-1:0] tag_valid;
  logic [ADDR_WIDTH-1:0] tag_addr [RD_LATENCY];
  logic [CHAN_WIDTH-1:0] tag_chan [RD_LATENCY];

  logic signed [DATA_WIDTH:0] diff;
  logic        [DATA_WIDTH:0] diff_mag;
  logic                       mismatch;

  // One extra bit keeps rtl - gld exact, so 7FFF vs 8000 cannot wrap to a small value.
  assign diff     = $signed({rtl_data[DATA_WIDTH-1], rtl_data})
                  - $signed({gld_data[DATA_WIDTH-1], gld_data});
  assign diff_mag = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign mismatch = diff_mag > TOL_V;
  assign pending  = |tag_valid;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid    <= '0;
      res_valid    <= 1'b0;
      res_mismatch <= 1'b0;
    end else if (flush) begin
      tag_valid    <= '0;
      res_valid    <= 1'b0;
      res_mismatch <= 1'b0;
    end else begin
      tag_valid[0] <= issue_valid;
      for (int i = 1; i < RD_LATENCY; i++) tag_valid[i] <= tag_valid[i-1];
      res_valid    <= tag_valid[RD_LATENCY-1];
      res_mismatch <= tag_valid[RD_LATENCY-1] & mismatch;
    end
  end

  // NOTE: payload registers have no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    tag_addr[0] <= issue_addr;
    tag_chan[0] <= issue_chan;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_addr[i] <= tag_addr[i-1];
      tag_chan[i] <= tag_chan[i-1];
    end
    res_addr <= tag_addr[RD_LATENCY-1];
    res_chan <= tag_chan[RD_LATENCY-1];
    res_rtl  <= rtl_data;
    res_gld  <= gld_data;
  end

endmodule

// File: rtl/ofm_checker.sv
// OFM self-check engine: sweeps dpram_ofm and a golden OFM word by word and
// reports pass/fail, mismatch count and the first mismatch. OFM_CHECKER_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module ofm_checker
  import ofm_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OFM_SIZE   = 26,
  parameter int NO_FILTER  = 128,
  parameter int RD_LATENCY = 1,
  parameter int TOL        = 0,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rtl_rd_data,
  input  logic [DATA_WIDTH-1:0] gld_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [CHAN_WIDTH-1:0] first_err_chan,
  output logic [DATA_WIDTH-1:0] first_err_rtl,
  output logic [DATA_WIDTH-1:0] first_err_gld
);

  localparam int                    N          = ofm_words(OFM_SIZE, NO_FILTER);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] PLANE_LAST = ADDR_WIDTH'(OFM_SIZE * OFM_SIZE - 1);
  localparam logic [31:0]           CNT_MAX    = 32'({ADDR_WIDTH{1'b1}});

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pix;
  logic [CHAN_WIDTH-1:0]   rd_chan;
  logic                    active, start_go, abort_go, hit, first_hit, stop_hit, flush, pending;
  logic                    res_valid, res_mismatch;
  logic [ADDR_WIDTH-1:0]   res_addr, err_next;
  logic [CHAN_WIDTH-1:0]   res_chan;
  logic [DATA_WIDTH-1:0]   res_rtl, res_gld;

  assign active    = (state == ST_READ) || (state == ST_DRAIN);
  assign start_go  = (state == ST_IDLE) && start && !abort;
  assign abort_go  = active && abort;
  assign hit       = active && res_valid && res_mismatch;
  assign first_hit = hit && (err_count == '0);
  assign err_next  = hit ? ADDR_WIDTH'(sat_inc(32'(err_count), CNT_MAX)) : err_count;

`ifdef OFM_CHECKER_STOP_ON_ERR_EN
  assign stop_hit = first_hit;
`else
  assign stop_hit = 1'b0;
`endif

  // Any verdicts still in flight belong to a sweep that is being cancelled or cut short.
  assign flush = start_go || abort_go || stop_hit;

  ofm_cmp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .TOL        (TOL)
  ) u_cmp_pipe (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (rd_en),
    .issue_addr   (rd_addr),
    .issue_chan   (rd_chan),
    .rtl_data     (rtl_rd_data),
    .gld_data     (gld_rd_data),
    .pending      (pending),
    .res_valid    (res_valid),
    .res_mismatch (res_mismatch),
    .res_addr     (res_addr),
    .res_chan     (res_chan),
    .res_rtl      (res_rtl),
    .res_gld      (res_gld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_chan <= '0;
      pix     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start_go) begin
          state   <= ST_READ;
          rd_en   <= 1'b1;
          rd_addr <= '0;
          rd_chan <= '0;
          pix     <= '0;
          busy    <= 1'b1;
          pass    <= 1'b0;
        end
        ST_READ: begin
          if (abort_go) begin
            state <= ST_IDLE;
            rd_en <= 1'b0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (stop_hit || rd_addr == LAST_ADDR) begin
            state <= ST_DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            // Channel is tracked alongside the address to avoid dividing by the plane size.
            if (pix == PLANE_LAST) begin
              pix     <= '0;
              rd_chan <= rd_chan + CHAN_WIDTH'(1);
            end else begin
              pix <= pix + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (abort_go) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (!pending) begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_chan <= '0;
      first_err_rtl  <= '0;
      first_err_gld  <= '0;
    end else if (start_go) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_chan <= '0;
      first_err_rtl  <= '0;
      first_err_gld  <= '0;
    end else begin
      err_count <= err_next;
      if (first_hit) begin
        first_err_addr <= res_addr;
        first_err_chan <= res_chan;
        first_err_rtl  <= res_rtl;
        first_err_gld  <= res_gld;
      end
    end
  end

endmodule
